// File: rtl/tproc_isa_pkg.sv
// Instruction-set constants shared by the dispatcher and its neighbours.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: opcode constants, opcode class enum, dispatcher FSM state enum,
// field widths, and an opcode classifier.
package tproc_isa_pkg;

    // Opcode occupies the top OPC_W bits of an instruction; the sub-op code
    // occupies the top SUBOP_W bits of the payload directly below it.
    localparam int OPC_W   = 8;
    localparam int SUBOP_W = 4;

    localparam logic [7:0] OP_NOP         = 8'h00;
    localparam logic [3:0] OP_DISPATCH_HI = 4'h1;
    localparam logic [7:0] OP_SYNC        = 8'h44;
    localparam logic [7:0] OP_HALT        = 8'h82;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DISPATCH  = 2'd1,
        ST_SYNC_WAIT = 2'd2,
        ST_HALT      = 2'd3
    } disp_state_e;

    typedef enum logic [2:0] {
        CLS_NOP      = 3'd0,
        CLS_DISPATCH = 3'd1,
        CLS_SYNC     = 3'd2,
        CLS_HALT     = 3'd3,
        CLS_ILLEGAL  = 3'd4
    } op_class_e;

    // DISPATCH to a unit index beyond the configured unit count is illegal.
    function automatic op_class_e classify(input logic [7:0] op, input int num_units);
        op_class_e cls;
        if (op == OP_NOP) begin
            cls = CLS_NOP;
        end else if (op[7:4] == OP_DISPATCH_HI) begin
            cls = (int'(op[3:0]) < num_units) ? CLS_DISPATCH : CLS_ILLEGAL;
        end else if (op == OP_SYNC) begin
            cls = CLS_SYNC;
        end else if (op == OP_HALT) begin
            cls = CLS_HALT;
        end else begin
            cls = CLS_ILLEGAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding fetched instructions ahead of decode.
// Latency: a word pushed at edge N is visible on pop_dat (and poppable) from N+1.
// Backpressure: push ignored while full (even with a same-cycle pop); pop ignored while empty.
//
// Ports: push_vld/push_dat write side, pop/pop_dat read side (show-ahead),
// full/empty derived from registered pointers with one extra wrap bit.
module instr_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    // Same index with differing wrap bits means the writer is a full lap ahead.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign push_ok = push_vld && !full;
    assign pop_ok  = pop && !empty;
    assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/instr_dispatch.sv
// Decodes queued instructions and hands payloads to NUM_UNITS execution units in order.
// Latency: accepted at edge N, popped/decoded at N+1, unit_valid held from N+1 until handshake.
// Backpressure: a stalled unit blocks all later instructions; in_ready drops when the FIFO is full.
//
// Ports: in_valid/in_ready/in_instr from the fetcher; unit_valid (one-hot),
// unit_ready, unit_busy, shared unit_payload/unit_subop to the units;
// start/halted for HALT control; sticky illegal_err.
// Optional: define INSTR_DISPATCH_PERF_EN to add perf_dispatch_cnt and
// perf_stall_cnt (32-bit, wrapping).
module instr_dispatch
    import tproc_isa_pkg::*;
#(
    parameter int INSTR_W    = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_UNITS  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INSTR_W-1:0]   in_instr,
    output logic [NUM_UNITS-1:0] unit_valid,
    input  logic [NUM_UNITS-1:0] unit_ready,
    input  logic [NUM_UNITS-1:0] unit_busy,
    output logic [INSTR_W-9:0]   unit_payload,
    output logic [3:0]           unit_subop,
    input  logic                 start,
    output logic                 halted,
    output logic                 illegal_err
`ifdef INSTR_DISPATCH_PERF_EN
    ,
    output logic [31:0]          perf_dispatch_cnt,
    output logic [31:0]          perf_stall_cnt
`endif
);

    localparam int PAY_W = INSTR_W - OPC_W;

    disp_state_e            state_q, state_d;
    logic [NUM_UNITS-1:0]   unit_valid_q, unit_valid_d;
    logic [PAY_W-1:0]       payload_q, payload_d;
    logic [SUBOP_W-1:0]     subop_q, subop_d;
    logic                   halted_q, halted_d;
    logic                   illegal_q, illegal_d;

    logic                   fifo_pop;
    logic [INSTR_W-1:0]     fifo_dat;
    logic                   fifo_full;
    logic                   fifo_empty;

    logic [OPC_W-1:0]       head_op;
    logic [PAY_W-1:0]       head_pay;
    op_class_e              head_cls;
    logic [NUM_UNITS-1:0]   head_onehot;
    logic                   handshake;
    logic                   take;

    instr_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (in_valid),
        .push_dat (in_instr),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign in_ready = !fifo_full;

    assign head_op  = fifo_dat[INSTR_W-1 -: OPC_W];
    assign head_pay = fifo_dat[PAY_W-1:0];
    assign head_cls = classify(head_op, NUM_UNITS);

    always_comb begin
        head_onehot = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            head_onehot[i] = (head_op[3:0] == 4'(i));
        end
    end

    assign handshake = (state_q == ST_DISPATCH) && ((unit_valid_q & unit_ready) != '0);

    // The FIFO head is decoded straight into the output registers, so a pop
    // on the handshake edge keeps a ready unit fed every cycle.
    always_comb begin
        state_d      = state_q;
        unit_valid_d = unit_valid_q;
        payload_d    = payload_q;
        subop_d      = subop_q;
        halted_d     = halted_q;
        illegal_d    = illegal_q;
        take         = 1'b0;
        fifo_pop     = 1'b0;

        if (start) begin
            illegal_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                take = !fifo_empty;
            end
            ST_DISPATCH: begin
                if (handshake) begin
                    unit_valid_d = '0;
                    state_d      = ST_IDLE;
                    take         = !fifo_empty;
                end
            end
            ST_SYNC_WAIT: begin
                if ((unit_busy == '0) && (unit_valid_q == '0)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                if (start) begin
                    state_d  = ST_IDLE;
                    halted_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (take) begin
            fifo_pop = 1'b1;
            case (head_cls)
                CLS_DISPATCH: begin
                    state_d      = ST_DISPATCH;
                    unit_valid_d = head_onehot;
                    payload_d    = head_pay;
                    subop_d      = head_pay[PAY_W-1 -: SUBOP_W];
                end
                CLS_SYNC: begin
                    state_d = ST_SYNC_WAIT;
                end
                CLS_HALT: begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end
                CLS_ILLEGAL: begin
                    // A new error wins over a same-cycle start clear.
                    state_d   = ST_IDLE;
                    illegal_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            unit_valid_q <= '0;
            payload_q    <= '0;
            subop_q      <= '0;
            halted_q     <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            unit_valid_q <= unit_valid_d;
            payload_q    <= payload_d;
            subop_q      <= subop_d;
            halted_q     <= halted_d;
            illegal_q    <= illegal_d;
        end
    end

    assign unit_valid   = unit_valid_q;
    assign unit_payload = payload_q;
    assign unit_subop   = subop_q;
    assign halted       = halted_q;
    assign illegal_err  = illegal_q;

`ifdef INSTR_DISPATCH_PERF_EN
    logic [31:0] dispatch_cnt_q, dispatch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stall;

    // A stall is any cycle a decoded instruction cannot retire.
    assign stall = ((state_q == ST_DISPATCH) && !handshake) || (state_q == ST_SYNC_WAIT);

    always_comb begin
        dispatch_cnt_d = dispatch_cnt_q + {31'd0, handshake};
        stall_cnt_d    = stall_cnt_q + {31'd0, stall};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dispatch_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            dispatch_cnt_q <= dispatch_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign perf_dispatch_cnt = dispatch_cnt_q;
    assign perf_stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_dispatch.sv
// Self-checking bench for instr_dispatch: directed scenarios plus a randomized
// stream scored against an in-order queue model of expected unit handshakes.
// Perf counters are checked only when INSTR_DISPATCH_PERF_EN is defined.
module tb_instr_dispatch;

    localparam int INSTR_W    = 64;
    localparam int FIFO_DEPTH = 4;
    localparam int NUM_UNITS  = 4;
    localparam int PAY_W      = INSTR_W - 8;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [INSTR_W-1:0]   in_instr;
    logic [NUM_UNITS-1:0] unit_valid;
    logic [NUM_UNITS-1:0] unit_ready;
    logic [NUM_UNITS-1:0] unit_busy;
    logic [PAY_W-1:0]     unit_payload;
    logic [3:0]           unit_subop;
    logic                 start;
    logic                 halted;
    logic                 illegal_err;
`ifdef INSTR_DISPATCH_PERF_EN
    logic [31:0]          perf_dispatch_cnt;
    logic [31:0]          perf_stall_cnt;
`endif

    instr_dispatch #(
        .INSTR_W    (INSTR_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .NUM_UNITS  (NUM_UNITS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .unit_valid   (unit_valid),
        .unit_ready   (unit_ready),
        .unit_busy    (unit_busy),
        .unit_payload (unit_payload),
        .unit_subop   (unit_subop),
        .start        (start),
        .halted       (halted),
        .illegal_err  (illegal_err)
`ifdef INSTR_DISPATCH_PERF_EN
        ,
        .perf_dispatch_cnt (perf_dispatch_cnt),
        .perf_stall_cnt    (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference model: expected handshakes in program order, plus error flag.
    int               exp_unit_q[$];
    logic [PAY_W-1:0] exp_pay_q[$];
    bit               exp_illegal;
    int               model_disp_cnt;
    bit               rand_done;

    function automatic logic [INSTR_W-1:0] mk(input logic [7:0] op, input logic [PAY_W-1:0] pay);
        return {op, pay};
    endfunction

    function automatic logic [PAY_W-1:0] rand_pay();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[PAY_W-1:0];
    endfunction

    // Apply the ISA rules to an accepted instruction.
    function automatic void model_accept(input logic [INSTR_W-1:0] instr);
        logic [7:0] op;
        op = instr[INSTR_W-1 -: 8];
        if (op[7:4] == 4'h1 && int'(op[3:0]) < NUM_UNITS) begin
            exp_unit_q.push_back(int'(op[3:0]));
            exp_pay_q.push_back(instr[PAY_W-1:0]);
        end else if (op != 8'h00 && op != 8'h44 && op != 8'h82) begin
            exp_illegal = 1'b1;
        end
    endfunction

    // Handshake scoreboard: inputs settle at posedge+1, so at negedge a
    // valid&ready pair means the handshake completes at the next posedge.
    int               mon_u;
    logic [PAY_W-1:0] mon_p;
    logic [3:0]       mon_oh;
    always @(negedge clk) begin
        if (rst_n && ((unit_valid & unit_ready) != '0)) begin
            vectors++;
            if (exp_unit_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_dispatch: valid=%b payload=%h, expected no dispatch", unit_valid, unit_payload);
            end else begin
                mon_u  = exp_unit_q.pop_front();
                mon_p  = exp_pay_q.pop_front();
                mon_oh = 4'b0001 << mon_u;
                model_disp_cnt++;
                if (unit_valid !== mon_oh || unit_payload !== mon_p || unit_subop !== mon_p[PAY_W-1 -: 4]) begin
                    errors++;
                    $display("FAIL dispatch_order: valid=%b payload=%h subop=%h, expected valid=%b payload=%h subop=%h",
                             unit_valid, unit_payload, unit_subop, mon_oh, mon_p, mon_p[PAY_W-1 -: 4]);
                end
            end
        end
    end

    task automatic do_reset();
        in_valid   = 1'b0;
        in_instr   = '0;
        start      = 1'b0;
        unit_busy  = '0;
        unit_ready = '1;
        rst_n      = 1'b0;
        exp_unit_q.delete();
        exp_pay_q.delete();
        exp_illegal    = 1'b0;
        model_disp_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Push one instruction, waiting (bounded) for in_ready.
    task automatic push(input logic [INSTR_W-1:0] instr);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_instr = instr;
        for (int k = 0; k < 300 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        vectors++;
        if (!acc) begin
            errors++;
            $display("FAIL push_timeout: in_ready stayed 0, expected acceptance of %h", instr);
        end else begin
            model_accept(instr);
        end
    endtask

    task automatic wait_drain(input int bound);
        bit drained;
        drained = 1'b0;
        for (int k = 0; k < bound && !drained; k++) begin
            if (exp_unit_q.size() == 0 && unit_valid == '0) drained = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        vectors++;
        if (!drained) begin
            errors++;
            $display("FAIL drain_timeout: %0d dispatches outstanding, valid=%b, expected 0", exp_unit_q.size(), unit_valid);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (unit_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b expected 0000", unit_valid); end
        vectors++; if (unit_payload !== '0) begin errors++; $display("FAIL reset_payload: got %h expected 0", unit_payload); end
        vectors++; if (unit_subop !== 4'h0) begin errors++; $display("FAIL reset_subop: got %h expected 0", unit_subop); end
        vectors++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        vectors++; if (illegal_err !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b expected 0", illegal_err); end
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
`ifdef INSTR_DISPATCH_PERF_EN
        vectors++;
        if (perf_dispatch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_perf: got %0d/%0d expected 0/0", perf_dispatch_cnt, perf_stall_cnt);
        end
`endif
    endtask

    // Three dispatches streamed back to back; first valid appears after the
    // edge following acceptance and units see one new valid per cycle.
    task automatic test_back_to_back();
        logic [INSTR_W-1:0] ins [3];
        logic [3:0]         exp_v [4];
        do_reset();
        ins[0] = mk(8'h10, rand_pay());
        ins[1] = mk(8'h11, rand_pay());
        ins[2] = mk(8'h13, rand_pay());
        exp_v[0] = 4'b0001; exp_v[1] = 4'b0010; exp_v[2] = 4'b1000; exp_v[3] = 4'b0000;
        in_valid = 1'b1;
        in_instr = ins[0];
        model_accept(ins[0]);
        @(posedge clk); #1;
        vectors++;
        if (unit_valid !== 4'b0000) begin errors++; $display("FAIL b2b_early: valid=%b expected 0000", unit_valid); end
        for (int c = 0; c < 4; c++) begin
            if (c < 2) begin
                in_instr = ins[c+1];
                model_accept(ins[c+1]);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            vectors++;
            if (unit_valid !== exp_v[c]) begin
                errors++;
                $display("FAIL b2b_cycle%0d: valid=%b expected %b", c, unit_valid, exp_v[c]);
            end
        end
        wait_drain(20);
    endtask

    task automatic test_stall_fill();
        logic [PAY_W-1:0]   p;
        logic [INSTR_W-1:0] oth [4];
        do_reset();
        unit_ready = 4'b1011;
        p = rand_pay();
        oth[0] = mk(8'h10, rand_pay());
        oth[1] = mk(8'h11, rand_pay());
        oth[2] = mk(8'h13, rand_pay());
        oth[3] = mk(8'h10, rand_pay());
        push(mk(8'h12, p));
        in_valid = 1'b1;
        in_instr = oth[0];
        model_accept(oth[0]);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (unit_valid !== 4'b0100 || unit_payload !== p || unit_subop !== p[PAY_W-1 -: 4]) begin
                errors++;
                $display("FAIL stall_hold%0d: valid=%b payload=%h expected 0100 payload=%h", c, unit_valid, unit_payload, p);
            end
            if (c < 4) begin
                in_instr = oth[c];
                model_accept(oth[c]);
            end else begin
                in_valid = 1'b0;
                vectors++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL fifo_full%0d: in_ready=%b expected 0", c, in_ready); end
            end
            if (c == 6) unit_ready = 4'b1111;
        end
        @(posedge clk); #1;
        vectors++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL fifo_unfull: in_ready=%b expected 1", in_ready); end
        wait_drain(40);
`ifdef INSTR_DISPATCH_PERF_EN
        vectors++;
        if (perf_stall_cnt !== 32'd5) begin errors++; $display("FAIL perf_stall: got %0d expected 5", perf_stall_cnt); end
        vectors++;
        if (perf_dispatch_cnt !== 32'(model_disp_cnt)) begin
            errors++;
            $display("FAIL perf_dispatch: got %0d expected %0d", perf_dispatch_cnt, model_disp_cnt);
        end
`endif
    endtask

    task automatic test_sync();
        bit seen;
        do_reset();
        unit_busy = 4'b0001;
        push(mk(8'h10, rand_pay()));
        push(mk(8'h44, '0));
        push(mk(8'h11, rand_pay()));
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (unit_valid[1] !== 1'b0) begin errors++; $display("FAIL sync_blocked%0d: valid=%b expected bit1=0", c, unit_valid); end
        end
        unit_busy = '0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk); #1;
            if (unit_valid[1] === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin errors++; $display("FAIL sync_release: valid=%b, expected bit1=1 after busy drop", unit_valid); end
        wait_drain(20);
    endtask

    task automatic test_halt();
        bit seen;
        do_reset();
        push(mk(8'h82, '0));
        push(mk(8'h10, rand_pay()));
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (halted !== 1'b1 || unit_valid !== 4'b0000) begin
                errors++;
                $display("FAIL halt_hold%0d: halted=%b valid=%b expected 1/0000", c, halted, unit_valid);
            end
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 3 && !seen; c++) begin
            if (unit_valid[0] === 1'b1) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        vectors++;
        if (!seen || halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_resume: valid=%b halted=%b expected bit0=1 halted=0", unit_valid, halted);
        end
        wait_drain(20);
    endtask

    task automatic test_illegal();
        do_reset();
        push(mk(8'h17, rand_pay()));
        push(mk(8'hAB, rand_pay()));
        push(mk(8'h11, rand_pay()));
        wait_drain(20);
        vectors++;
        if (illegal_err !== 1'b1) begin errors++; $display("FAIL illegal_set: got %b expected 1", illegal_err); end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vectors++;
        if (illegal_err !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL illegal_clear: illegal=%b halted=%b expected 0/0", illegal_err, halted);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        unit_ready = 4'b1110;
        push(mk(8'h10, rand_pay()));
        push(mk(8'h11, rand_pay()));
        push(mk(8'h12, rand_pay()));
        @(posedge clk); #1;
        vectors++;
        if (unit_valid !== 4'b0001) begin errors++; $display("FAIL mid_stall: valid=%b expected 0001", unit_valid); end
        #2;
        rst_n = 1'b0;
        exp_unit_q.delete();
        exp_pay_q.delete();
        #1;
        vectors++;
        if (unit_valid !== 4'b0000 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_async_reset: valid=%b in_ready=%b expected 0000/1", unit_valid, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        unit_ready = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (unit_valid !== 4'b0000) begin errors++; $display("FAIL mid_fifo_empty%0d: valid=%b expected 0000", c, unit_valid); end
        end
    endtask

    task automatic test_random();
        logic [7:0] op;
        int         r;
        do_reset();
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    r = $urandom_range(0, 99);
                    if (r < 55)      op = {4'h1, 4'($urandom_range(0, NUM_UNITS-1))};
                    else if (r < 67) op = 8'h00;
                    else if (r < 77) op = {4'h1, 4'($urandom_range(NUM_UNITS, 15))};
                    else if (r < 82) op = 8'h44;
                    else begin
                        op = 8'hAB;
                        for (int t = 0; t < 20; t++) begin
                            op = 8'($urandom_range(0, 255));
                            if (op != 8'h00 && op[7:4] != 4'h1 && op != 8'h44 && op != 8'h82) break;
                            op = 8'hAB;
                        end
                    end
                    push(mk(op, rand_pay()));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    unit_ready = 4'($urandom_range(0, 15));
                end
            end
        join
        unit_ready = 4'b1111;
        wait_drain(400);
        vectors++;
        if (illegal_err !== exp_illegal) begin
            errors++;
            $display("FAIL random_illegal: got %b expected %b", illegal_err, exp_illegal);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        unit_ready = '1;
        unit_busy = '0;
        start = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_back_to_back();
        test_stall_fill();
        test_sync();
        test_halt();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
